// File: rtl/noc_pkg.sv
// noc_pkg: constants, opcodes and FSM state type shared by the NoC network-interface blocks.
// Revision: 1.0
`default_nettype none

package noc_pkg;

  localparam int FLIT_WIDTH_DEF = 80;
  localparam int OPCODE_WIDTH   = 2;

  localparam logic [OPCODE_WIDTH-1:0] OP_READ  = 2'b00;
  localparam logic [OPCODE_WIDTH-1:0] OP_WRITE = 2'b01;

  // Header field LSB positions, derived from the flit MSB downwards.
  function automatic int hdr_op_lsb(input int flit_w, input int route_w);
    return flit_w - route_w - OPCODE_WIDTH;
  endfunction

  function automatic int hdr_len_lsb(input int flit_w, input int route_w, input int len_w);
    return hdr_op_lsb(flit_w, route_w) - len_w;
  endfunction

  function automatic int hdr_addr_lsb(input int flit_w, input int route_w, input int len_w,
                                      input int addr_w);
    return hdr_len_lsb(flit_w, route_w, len_w) - addr_w;
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BODY = 1'b1
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/ni_tx_fifo.sv
// ni_tx_fifo: synchronous payload FIFO with asynchronous reset; push ignored when full, pop when empty.
// Revision: 1.0
`default_nettype none

module ni_tx_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
      else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ni_flit_tx.sv
// ni_flit_tx: NI injection side; packetizes requests into header/body flits with stall backpressure.
// Optional statistics counters enabled by defining NI_TX_STATS_EN.  Revision: 1.0
`default_nettype none

module ni_flit_tx
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH    = FLIT_WIDTH_DEF,
  parameter int ROUTE_WIDTH   = 30,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int LOG_MAX_BURST = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ROUTE_WIDTH-1:0]    req_route,
  input  logic [1:0]                req_opcode,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [LOG_MAX_BURST-1:0]  req_len,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  output logic [FLIT_WIDTH-1:0]     FLIT_out,
  output logic                      VALID_out,
  output logic                      FWDAUX1_out,
  input  logic                      BWDAUX1_in,
  input  logic                      BWDAUX2_in,
`ifdef NI_TX_STATS_EN
  input  logic                      BWDAUX3_in,
  output logic [31:0]               stat_flits,
  output logic [31:0]               stat_pkts,
  output logic [31:0]               stat_stalls
`else
  input  logic                      BWDAUX3_in
`endif
);

  localparam int BEAT_W   = DATA_WIDTH + DATA_WIDTH/8;
  localparam int OP_LSB   = hdr_op_lsb(FLIT_WIDTH, ROUTE_WIDTH);
  localparam int LEN_LSB  = hdr_len_lsb(FLIT_WIDTH, ROUTE_WIDTH, LOG_MAX_BURST);
  localparam int ADDR_LSB = hdr_addr_lsb(FLIT_WIDTH, ROUTE_WIDTH, LOG_MAX_BURST, ADDR_WIDTH);

  tx_state_t                state;
  logic [LOG_MAX_BURST-1:0] cnt;
  logic                     out_free;
  logic                     is_write;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_pop;
  logic [BEAT_W-1:0]        fifo_data;
  logic [FLIT_WIDTH-1:0]    hdr_flit;
  logic [FLIT_WIDTH-1:0]    body_flit;
  logic                     unused_aux;

  assign unused_aux = BWDAUX2_in ^ BWDAUX3_in;

  assign out_free  = ~VALID_out | ~BWDAUX1_in;
  assign req_ready = (state == IDLE) & out_free;
  assign is_write  = (req_opcode == OP_WRITE);
  assign wr_ready  = ~fifo_full;
  assign fifo_pop  = (state == BODY) & out_free & ~fifo_empty;

  always_comb begin
    hdr_flit = '0;
    hdr_flit[FLIT_WIDTH-1 -: ROUTE_WIDTH]  = req_route;
    hdr_flit[OP_LSB +: OPCODE_WIDTH]       = req_opcode;
    hdr_flit[LEN_LSB +: LOG_MAX_BURST]     = req_len;
    hdr_flit[ADDR_LSB +: ADDR_WIDTH]       = req_addr;
    body_flit = '0;
    body_flit[BEAT_W-1:0] = fifo_data;
  end

  ni_tx_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid),
    .push_data ({wr_be, wr_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Output register only moves when the current flit has been taken (or none is pending).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      FLIT_out    <= '0;
      VALID_out   <= 1'b0;
      FWDAUX1_out <= 1'b0;
    end else if (out_free) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            FLIT_out  <= hdr_flit;
            VALID_out <= 1'b1;
            if (is_write) begin
              FWDAUX1_out <= 1'b0;
              cnt         <= req_len;
              state       <= BODY;
            end else begin
              FWDAUX1_out <= 1'b1;
            end
          end else begin
            VALID_out   <= 1'b0;
            FWDAUX1_out <= 1'b0;
          end
        end
        BODY: begin
          if (!fifo_empty) begin
            FLIT_out    <= body_flit;
            VALID_out   <= 1'b1;
            FWDAUX1_out <= (cnt == '0);
            if (cnt == '0) state <= IDLE;
            else           cnt   <= cnt - LOG_MAX_BURST'(1);
          end else begin
            VALID_out   <= 1'b0;
            FWDAUX1_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NI_TX_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_flits  <= '0;
      stat_pkts   <= '0;
      stat_stalls <= '0;
    end else begin
      if (VALID_out && !BWDAUX1_in && stat_flits != '1)                stat_flits  <= stat_flits + 32'd1;
      if (VALID_out && !BWDAUX1_in && FWDAUX1_out && stat_pkts != '1) stat_pkts   <= stat_pkts + 32'd1;
      if (VALID_out && BWDAUX1_in && stat_stalls != '1)               stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ni_flit_tx.sv
// tb_ni_flit_tx: directed self-checking bench for ni_flit_tx (default parameters).
// Revision: 1.0
`default_nettype none

module tb_ni_flit_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [29:0] req_route = '0;
  logic [1:0]  req_opcode = '0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_be = '0;
  logic [79:0] FLIT_out;
  logic        VALID_out;
  logic        FWDAUX1_out;
  logic        BWDAUX1_in = 1'b0;
  logic        BWDAUX2_in = 1'b0;
  logic        BWDAUX3_in = 1'b0;
`ifdef NI_TX_STATS_EN
  logic [31:0] stat_flits, stat_pkts, stat_stalls;
`endif

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ni_flit_tx dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_route(req_route),
    .req_opcode(req_opcode), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_be(wr_be),
    .FLIT_out(FLIT_out), .VALID_out(VALID_out), .FWDAUX1_out(FWDAUX1_out),
    .BWDAUX1_in(BWDAUX1_in), .BWDAUX2_in(BWDAUX2_in),
`ifdef NI_TX_STATS_EN
    .BWDAUX3_in(BWDAUX3_in),
    .stat_flits(stat_flits), .stat_pkts(stat_pkts), .stat_stalls(stat_stalls)
`else
    .BWDAUX3_in(BWDAUX3_in)
`endif
  );

  // Header: route[79:50] opcode[49:48] len[47:44] addr[43:12] zero[11:0]
  function automatic logic [79:0] hdr(input logic [29:0] r, input logic [1:0] op,
                                      input logic [3:0] len, input logic [31:0] a);
    return {r, op, len, a, 12'h000};
  endfunction

  function automatic logic [63:0] beat_data(input int tag);
    return 64'h1111_2222_3333_0000 + 64'(tag);
  endfunction

  function automatic logic [7:0] beat_be(input int tag);
    return 8'hF0 ^ 8'(tag);
  endfunction

  function automatic logic [79:0] body(input int tag);
    return {8'h00, beat_be(tag), beat_data(tag)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flit(input string name, input logic v, input logic t, input logic [79:0] f);
    tests_run++;
    if (VALID_out !== v || FWDAUX1_out !== t || (v && FLIT_out !== f)) begin
      fails++;
      $display("FAIL %s: got valid=%0b tail=%0b flit=%h, want valid=%0b tail=%0b flit=%h",
               name, VALID_out, FWDAUX1_out, FLIT_out, v, t, f);
    end
  endtask

  task automatic push_beats(input int n, input int tag0);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = beat_data(tag0 + i);
      wr_be    = beat_be(tag0 + i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic issue(input logic [29:0] r, input logic [1:0] op, input logic [3:0] len,
                       input logic [31:0] a);
    req_valid = 1'b1; req_route = r; req_opcode = op; req_len = len; req_addr = a;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL req_ready_idle: got %0b want 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (VALID_out !== 1'b0 || FLIT_out !== 80'h0 || FWDAUX1_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%0b flit=%h tail=%0b want 0/0/0",
               VALID_out, FLIT_out, FWDAUX1_out);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_req_ready: got %0b want 1", req_ready);
    end
    tests_run++;
    if (wr_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_wr_ready: got %0b want 1", wr_ready);
    end
  endtask

  task automatic test_read();
    issue(30'h155, 2'b00, 4'h7, 32'h1000_0040);
    chk_flit("read_header", 1'b1, 1'b1, hdr(30'h155, 2'b00, 4'h7, 32'h1000_0040));
    tick();
    chk_flit("read_idle_after", 1'b0, 1'b0, '0);
    // Reserved opcode behaves as a single-flit read.
    issue(30'h3FFF_FFFF, 2'b11, 4'h2, 32'hFFFF_FFFF);
    chk_flit("reserved_op_header", 1'b1, 1'b1, hdr(30'h3FFF_FFFF, 2'b11, 4'h2, 32'hFFFF_FFFF));
    tick();
    chk_flit("reserved_op_idle", 1'b0, 1'b0, '0);
  endtask

  task automatic test_write_burst();
    push_beats(4, 16);
    tests_run++;
    if (wr_ready !== 1'b0) begin
      fails++;
      $display("FAIL fifo_full_wr_ready: got %0b want 0", wr_ready);
    end
    issue(30'h2AA, 2'b01, 4'd3, 32'h2000_0000);
    chk_flit("wr_header", 1'b1, 1'b0, hdr(30'h2AA, 2'b01, 4'd3, 32'h2000_0000));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_flit($sformatf("wr_body%0d", i), 1'b1, (i == 3), body(16 + i));
    end
    tick();
    chk_flit("wr_after_tail", 1'b0, 1'b0, '0);
  endtask

  task automatic test_write_stall();
    push_beats(4, 32);
    issue(30'h0AB, 2'b01, 4'd3, 32'h0000_1230);
    chk_flit("st_header", 1'b1, 1'b0, hdr(30'h0AB, 2'b01, 4'd3, 32'h0000_1230));
    tick();
    chk_flit("st_body0", 1'b1, 1'b0, body(32));
    tick();
    chk_flit("st_body1", 1'b1, 1'b0, body(33));
    BWDAUX1_in = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL st_req_ready: got %0b want 0", req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_flit($sformatf("st_hold%0d", i), 1'b1, 1'b0, body(33));
    end
    BWDAUX1_in = 1'b0;
    tick();
    chk_flit("st_body2", 1'b1, 1'b0, body(34));
    tick();
    chk_flit("st_body3", 1'b1, 1'b1, body(35));
    tick();
    chk_flit("st_done", 1'b0, 1'b0, '0);
  endtask

  task automatic test_write_gap();
    push_beats(1, 48);
    issue(30'h001, 2'b01, 4'd1, 32'hABCD_0008);
    chk_flit("gap_header", 1'b1, 1'b0, hdr(30'h001, 2'b01, 4'd1, 32'hABCD_0008));
    tick();
    chk_flit("gap_body0", 1'b1, 1'b0, body(48));
    tick();
    chk_flit("gap_idle1", 1'b0, 1'b0, '0);
    wr_valid = 1'b1; wr_data = beat_data(49); wr_be = beat_be(49);
    tick();
    wr_valid = 1'b0;
    chk_flit("gap_idle2", 1'b0, 1'b0, '0);
    tick();
    chk_flit("gap_body1", 1'b1, 1'b1, body(49));
    tick();
    chk_flit("gap_done", 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    push_beats(4, 64);
    issue(30'h0CC, 2'b01, 4'd3, 32'h5555_0000);
    tick();
    chk_flit("rm_body0", 1'b1, 1'b0, body(64));
    rst = 1'b1;
    #1;
    tests_run++;
    if (VALID_out !== 1'b0 || FLIT_out !== 80'h0 || FWDAUX1_out !== 1'b0) begin
      fails++;
      $display("FAIL rm_async_clear: got valid=%0b flit=%h tail=%0b want 0/0/0",
               VALID_out, FLIT_out, FWDAUX1_out);
    end
    tick();
    rst = 1'b0;
    tick();
    issue(30'h0DD, 2'b00, 4'd0, 32'h0000_0100);
    chk_flit("rm_read_header", 1'b1, 1'b1, hdr(30'h0DD, 2'b00, 4'd0, 32'h0000_0100));
    tick();
    chk_flit("rm_read_idle", 1'b0, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_burst();
    test_write_stall();
    test_write_gap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

`default_nettype wire
